// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
//
// Supplies the frame ID and the H/V display offsets that the SDRAM-to-VGA-FIFO
// reader uses to fetch each image. In auto mode it steps through a latched
// range of stored images and holds each one for a programmable number of VGA
// frames. In manual mode it passes a directly supplied frame ID through.
// Every output changes only at a VGA vertical-sync boundary. A boundary is a
// detected falling edge of the synchronised iVSYNC_N.
//
// Output qualification: there is no valid/ready handshake. oFRAME_TICK is a
// one-cycle strobe that marks the cycle in which oFRAME_ID and the four
// offset outputs take new values. oWRAP is only ever high together with
// oFRAME_TICK. Consumers may sample the outputs at any time; they stay stable
// between ticks.
//
// Ports
//   iCLK            SDRAM-controller clock, the single clock domain
//   iRST_N          synchronous reset, active-low
//   iENABLE         sequencing allowed (SDRAM write-done)
//   iRUN            1 = auto-sequence, 0 = manual
//   iVSYNC_N        VGA vertical sync, active-low, asynchronous to iCLK
//   iMANUAL_FRAME   frame shown in manual mode
//   iFIRST_FRAME    first frame of the sequence (inclusive)
//   iLAST_FRAME     last frame of the sequence (inclusive)
//   iDWELL          VGA frames per image; 0 is treated as 1
//   iOFFSET_*       offset signs and magnitudes, latched at boundaries
//   oFRAME_ID       frame ID for the reader
//   oOFFSET_*       latched offset signs and magnitudes
//   oFRAME_TICK     one-cycle pulse on every output update
//   oWRAP           one-cycle pulse when the sequence returns to its first frame
//   oSTATE          state monitor: 0 = IDLE, 1 = MANUAL, 2 = RUN
// ---------------------------------------------------------------------------
module frame_sequencer #(
   parameter int FRAME_BITS = 6,
   parameter int DWELL_BITS = 8
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iENABLE,
   input  logic                  iRUN,
   input  logic                  iVSYNC_N,
   input  logic [FRAME_BITS-1:0] iMANUAL_FRAME,
   input  logic [FRAME_BITS-1:0] iFIRST_FRAME,
   input  logic [FRAME_BITS-1:0] iLAST_FRAME,
   input  logic [DWELL_BITS-1:0] iDWELL,
   input  logic                  iOFFSET_H_SIGN,
   input  logic                  iOFFSET_V_SIGN,
   input  logic [7:0]            iOFFSET_H,
   input  logic [7:0]            iOFFSET_V,
   output logic [FRAME_BITS-1:0] oFRAME_ID,
   output logic                  oOFFSET_H_SIGN,
   output logic                  oOFFSET_V_SIGN,
   output logic [7:0]            oOFFSET_H,
   output logic [7:0]            oOFFSET_V,
   output logic                  oFRAME_TICK,
   output logic                  oWRAP,
   output logic [1:0]            oSTATE
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam logic [FRAME_BITS-1:0] FRAME_ONE = {{(FRAME_BITS-1){1'b0}}, 1'b1};
   localparam logic [DWELL_BITS-1:0] DWELL_ONE = {{(DWELL_BITS-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Vsync synchroniser and falling-edge detector.
   // vs_s1/vs_s2 form the two-flop synchroniser, vs_s3 is the delayed copy
   // for edge detection. The detected edge is registered once more so the
   // sequencer acts three edges after stage 1 first captures the low level.
   // Reset value is 1 (sync inactive) so releasing reset never fakes an edge.
   // ------------------------------------------------------------------------
   logic vs_s1;
   logic vs_s2;
   logic vs_s3;
   logic boundary;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         vs_s1    <= 1'b1;
         vs_s2    <= 1'b1;
         vs_s3    <= 1'b1;
         boundary <= 1'b0;
      end else begin
         vs_s1    <= iVSYNC_N;
         vs_s2    <= vs_s1;
         vs_s3    <= vs_s2;
         boundary <= vs_s3 & ~vs_s2;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------------
   state_t                state;
   logic [FRAME_BITS-1:0] first_q;
   logic [FRAME_BITS-1:0] last_q;
   logic [DWELL_BITS-1:0] dwell_q;
   logic [FRAME_BITS-1:0] cur;
   logic [DWELL_BITS-1:0] cnt;
   logic                  primed;

   // Advancing from the last frame, or from any frame of an inverted
   // (last < first) range, goes back to the first frame. Because of this
   // cur only increments while cur < last, so cur + 1 cannot overflow.
   logic                  wrap_now;
   logic [FRAME_BITS-1:0] cur_inc;
   logic [DWELL_BITS-1:0] dwell_eff;

   always_comb begin
      wrap_now  = (cur == last_q) || (last_q < first_q);
      cur_inc   = cur + FRAME_ONE;
      dwell_eff = (iDWELL == '0) ? DWELL_ONE : iDWELL;
   end

   assign oSTATE = state;

   // Single sequencer process. A state change and a boundary in the same
   // cycle: the state change wins and the boundary is dropped entirely.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state          <= ST_IDLE;
         first_q        <= '0;
         last_q         <= '0;
         dwell_q        <= '0;
         cur            <= '0;
         cnt            <= '0;
         primed         <= 1'b0;
         oFRAME_ID      <= '0;
         oOFFSET_H_SIGN <= 1'b0;
         oOFFSET_V_SIGN <= 1'b0;
         oOFFSET_H      <= '0;
         oOFFSET_V      <= '0;
         oFRAME_TICK    <= 1'b0;
         oWRAP          <= 1'b0;
      end else begin
         oFRAME_TICK <= 1'b0;
         oWRAP       <= 1'b0;

         case (state)
            ST_IDLE: begin
               // Boundaries are ignored; outputs hold their last values.
               if (iENABLE) begin
                  if (iRUN) begin
                     state   <= ST_RUN;
                     first_q <= iFIRST_FRAME;
                     last_q  <= iLAST_FRAME;
                     dwell_q <= dwell_eff;
                     cur     <= iFIRST_FRAME;
                     cnt     <= '0;
                     primed  <= 1'b0;
                  end else begin
                     state <= ST_MANUAL;
                  end
               end
            end

            ST_MANUAL: begin
               if (!iENABLE) begin
                  state <= ST_IDLE;
               end else if (iRUN) begin
                  state   <= ST_RUN;
                  first_q <= iFIRST_FRAME;
                  last_q  <= iLAST_FRAME;
                  dwell_q <= dwell_eff;
                  cur     <= iFIRST_FRAME;
                  cnt     <= '0;
                  primed  <= 1'b0;
               end else if (boundary) begin
                  oFRAME_ID      <= iMANUAL_FRAME;
                  oOFFSET_H_SIGN <= iOFFSET_H_SIGN;
                  oOFFSET_V_SIGN <= iOFFSET_V_SIGN;
                  oOFFSET_H      <= iOFFSET_H;
                  oOFFSET_V      <= iOFFSET_V;
                  oFRAME_TICK    <= 1'b1;
               end
            end

            ST_RUN: begin
               if (!iENABLE) begin
                  state <= ST_IDLE;
               end else if (!iRUN) begin
                  state <= ST_MANUAL;
               end else if (boundary) begin
                  oOFFSET_H_SIGN <= iOFFSET_H_SIGN;
                  oOFFSET_V_SIGN <= iOFFSET_V_SIGN;
                  oOFFSET_H      <= iOFFSET_H;
                  oOFFSET_V      <= iOFFSET_V;
                  oFRAME_TICK    <= 1'b1;
                  if (!primed) begin
                     // First boundary after entry shows the first frame and
                     // starts its dwell.
                     oFRAME_ID <= first_q;
                     cnt       <= DWELL_ONE;
                     primed    <= 1'b1;
                  end else if (cnt < dwell_q) begin
                     // Still dwelling: cnt never exceeds dwell_q, so it
                     // saturates naturally at the largest dwell.
                     cnt       <= cnt + DWELL_ONE;
                     oFRAME_ID <= cur;
                  end else begin
                     cnt <= DWELL_ONE;
                     if (wrap_now) begin
                        cur       <= first_q;
                        oFRAME_ID <= first_q;
                        oWRAP     <= 1'b1;
                     end else begin
                        cur       <= cur_inc;
                        oFRAME_ID <= cur_inc;
                     end
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
//
// Self-checking bench for frame_sequencer. Stimulus tasks push the expected
// output record into exp_q whenever they issue a vsync that should update the
// outputs; an independent monitor pops and compares on every oFRAME_TICK.
// The reference model describes auto-sequencing arithmetically: boundary k
// after RUN entry shows image floor((k-1)/dwell) of the range, modulo the
// range length.
// ---------------------------------------------------------------------------
module tb_frame_sequencer;

   localparam int FB = 6;
   localparam int DB = 8;
   localparam int W  = FB + 1 + 8 + 1 + 8 + 1;

   // ------------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          enable;
   logic          run;
   logic          vsync_n;
   logic [FB-1:0] manual_frame;
   logic [FB-1:0] first_frame;
   logic [FB-1:0] last_frame;
   logic [DB-1:0] dwell;
   logic          h_sign_in;
   logic          v_sign_in;
   logic [7:0]    off_h_in;
   logic [7:0]    off_v_in;
   logic [FB-1:0] frame_id;
   logic          h_sign;
   logic          v_sign;
   logic [7:0]    off_h;
   logic [7:0]    off_v;
   logic          tick;
   logic          wrap;
   logic [1:0]    state;

   frame_sequencer #(
      .FRAME_BITS(FB),
      .DWELL_BITS(DB)
   ) dut (
      .iCLK          (clk),
      .iRST_N        (rst_n),
      .iENABLE       (enable),
      .iRUN          (run),
      .iVSYNC_N      (vsync_n),
      .iMANUAL_FRAME (manual_frame),
      .iFIRST_FRAME  (first_frame),
      .iLAST_FRAME   (last_frame),
      .iDWELL        (dwell),
      .iOFFSET_H_SIGN(h_sign_in),
      .iOFFSET_V_SIGN(v_sign_in),
      .iOFFSET_H     (off_h_in),
      .iOFFSET_V     (off_v_in),
      .oFRAME_ID     (frame_id),
      .oOFFSET_H_SIGN(h_sign),
      .oOFFSET_V_SIGN(v_sign),
      .oOFFSET_H     (off_h),
      .oOFFSET_V     (off_v),
      .oFRAME_TICK   (tick),
      .oWRAP         (wrap),
      .oSTATE        (state)
   );

   // ------------------------------------------------------------------------
   // Scoreboard state and reference model
   // ------------------------------------------------------------------------
   int            checks = 0;
   int            passes = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  mon_exp;
   int            mode = 0;   // 0 idle, 1 manual, 2 run
   int            m_first;
   int            m_last;
   int            m_dwell;
   int            m_k;
   logic [7:0]    last_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   task automatic enter_run();
      mode    = 2;
      m_first = int'(first_frame);
      m_last  = int'(last_frame);
      m_dwell = int'(dwell);
      m_k     = 0;
   endtask

   // Expected record for the boundary being issued now.
   task automatic push_expected();
      int           len;
      int           d;
      int           idx;
      logic [FB-1:0] f;
      logic         w;
      if (mode == 1) begin
         exp_q.push_back({manual_frame, h_sign_in, off_h_in, v_sign_in, off_v_in, 1'b0});
         last_v = off_v_in;
      end else if (mode == 2) begin
         m_k++;
         len = (m_last >= m_first) ? (m_last - m_first + 1) : 1;
         d   = (m_dwell == 0) ? 1 : m_dwell;
         idx = (m_k - 1) / d;
         f   = FB'(m_first + (idx % len));
         w   = (m_k > 1) && (((m_k - 1) % d) == 0) && ((idx % len) == 0);
         exp_q.push_back({f, h_sign_in, off_h_in, v_sign_in, off_v_in, w});
         last_v = off_v_in;
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst_n && tick) begin
         if (exp_q.size() == 0) begin
            check("unexpected_tick", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_exp = exp_q.pop_front();
            check("frame_update", 32'({frame_id, h_sign, off_h, v_sign, off_v, wrap}),
                  32'(mon_exp));
         end
      end else if (rst_n && wrap) begin
         check("wrap_without_tick", 32'(tick), 32'd1);
      end
   end

   // ------------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------------
   task automatic randomize_boundary_inputs();
      manual_frame = FB'($urandom_range(0, (1 << FB) - 1));
      h_sign_in    = 1'($urandom_range(0, 1));
      v_sign_in    = 1'($urandom_range(0, 1));
      off_h_in     = 8'($urandom_range(0, 255));
      off_v_in     = 8'($urandom_range(0, 255));
   endtask

   task automatic set_mode(input bit en_v, input bit run_v);
      @(negedge clk);
      enable = en_v;
      run    = run_v;
      if (!en_v) mode = 0;
      else if (run_v) begin
         if (mode != 2) enter_run();
      end else mode = 1;
      repeat (2) @(negedge clk);
      check("state", 32'(state), 32'(mode));
   endtask

   // sw: 0 = plain boundary, 1 = enable+run rise on the boundary's action
   // edge, 2 = run rises on the boundary's action edge. For sw != 0 the
   // boundary must be dropped.
   task automatic vsync_pulse(input bit rand_inputs, input int sw);
      bit expect_upd;
      @(negedge clk);
      if (rand_inputs) randomize_boundary_inputs();
      vsync_n    = 1'b0;
      expect_upd = (sw == 0) && (mode != 0);
      if (sw == 0) push_expected();
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (sw == 1) begin
         enable = 1'b1;
         run    = 1'b1;
         enter_run();
      end else if (sw == 2) begin
         run = 1'b1;
         enter_run();
      end else if (expect_upd) begin
         check("tick_latency", 32'(tick), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      check("tick_missing", 32'(exp_q.size()), 32'd0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      vsync_n = 1'b1;
      repeat ($urandom_range(4, 8)) @(negedge clk);
   endtask

   task automatic set_range(input int f, input int l, input int d);
      @(negedge clk);
      first_frame = FB'(f);
      last_frame  = FB'(l);
      dwell       = DB'(d);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      rst_n        = 1'b0;
      enable       = 1'b0;
      run          = 1'b0;
      vsync_n      = 1'b1;
      first_frame  = '0;
      last_frame   = '0;
      dwell        = '0;
      randomize_boundary_inputs();

      // Reset held with random inputs and vsync activity.
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         enable      = 1'($urandom_range(0, 1));
         run         = 1'($urandom_range(0, 1));
         vsync_n     = (i % 8) >= 4;
         first_frame = FB'($urandom_range(0, 63));
         randomize_boundary_inputs();
         if (i % 5 == 4)
            check("reset_outputs",
                  32'({frame_id, h_sign, off_h, v_sign, off_v, tick, wrap, state}), 32'd0);
      end
      @(negedge clk);
      enable  = 1'b0;
      run     = 1'b0;
      vsync_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mode  = 0;
      repeat (3) @(negedge clk);

      // Manual mode.
      manual_frame = 6'd5;
      off_h_in     = 8'h12;
      h_sign_in    = 1'b1;
      set_mode(1'b1, 1'b0);
      vsync_pulse(1'b0, 0);
      check("manual_frame_hold", 32'(frame_id), 32'd5);

      // Sequencing 2..4, dwell 2.
      set_range(2, 4, 2);
      set_mode(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) vsync_pulse(1'b1, 0);

      // Dwell 0 treated as 1, range 1..3.
      set_mode(1'b1, 1'b0);
      set_range(1, 3, 0);
      set_mode(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) vsync_pulse(1'b1, 0);

      // Inverted range 7..3.
      set_mode(1'b1, 1'b0);
      set_range(7, 3, 1);
      set_mode(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) vsync_pulse(1'b1, 0);

      // Enable drop after three frames of 0..9.
      set_mode(1'b1, 1'b0);
      set_range(0, 9, 1);
      set_mode(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) vsync_pulse(1'b1, 0);
      set_mode(1'b0, 1'b1);
      check("drop_hold_frame", 32'(frame_id), 32'd2);
      for (int i = 0; i < 2; i++) vsync_pulse(1'b1, 0);
      check("idle_hold_frame", 32'(frame_id), 32'd2);
      vsync_pulse(1'b1, 1);
      check("reenable_state", 32'(state), 32'd2);
      vsync_pulse(1'b1, 0);
      check("reenable_first", 32'(frame_id), 32'd0);

      // Manual -> run transition coincident with a boundary.
      set_mode(1'b1, 1'b0);
      vsync_pulse(1'b1, 0);
      set_range(3, 5, 1);
      @(negedge clk);
      run = 1'b0;
      vsync_pulse(1'b1, 2);
      vsync_pulse(1'b1, 0);
      vsync_pulse(1'b1, 0);

      // Mid-frame offset change is invisible until the next boundary.
      @(negedge clk);
      off_v_in = ~off_v_in;
      repeat (5) @(negedge clk);
      check("offset_v_hold", 32'(off_v), 32'(last_v));
      vsync_pulse(1'b0, 0);

      // Randomised phase: mode changes, range changes (ignored while in RUN)
      // and boundaries.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            set_range($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            set_mode($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
         end else begin
            vsync_pulse(1'b1, 0);
         end
      end

      // Reset asserted mid-run.
      set_mode(1'b1, 1'b0);
      set_range(4, 6, 1);
      set_mode(1'b1, 1'b1);
      vsync_pulse(1'b1, 0);
      vsync_pulse(1'b1, 0);
      @(negedge clk);
      rst_n  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      check("midrun_reset",
            32'({frame_id, h_sign, off_h, v_sign, off_v, tick, wrap, state}), 32'd0);
      rst_n = 1'b1;
      mode  = 0;
      repeat (2) @(negedge clk);
      set_mode(1'b1, 1'b1);
      vsync_pulse(1'b1, 0);
      vsync_pulse(1'b1, 0);

      repeat (6) @(negedge clk);
      check("queue_empty_end", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Watchdog: the stimulus is bounded, but never let the run hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame sequencer between the host control path and the SDRAM-to-VGA-FIFO reader. It supplies the frame ID and the H/V display offsets that the reader uses to fetch each image. It steps through a host-programmed range of stored images, holding each one for a programmable number of VGA frames. All outputs change only at VGA vertical-sync boundaries, so the reader never sees a frame ID or offset change partway through a displayed frame. A manual mode passes a directly supplied frame ID through, also at frame boundaries.

## Interface
- FRAME_BITS, 6, width of frame IDs
- DWELL_BITS, 8, width of dwell count
- iCLK  in  1  SDRAM-controller clock; single clock domain
- iRST_N  in  1  synchronous reset, active-low
- iENABLE  in  1  sequencing allowed; driven by SDRAM write-done
- iRUN  in  1  1 = auto-sequence, 0 = manual
- iVSYNC_N  in  1  VGA vertical sync, active-low, asynchronous to iCLK
- iMANUAL_FRAME  in  FRAME_BITS  frame shown in manual mode
- iFIRST_FRAME, iLAST_FRAME  in  FRAME_BITS  inclusive sequence range
- iDWELL  in  DWELL_BITS  VGA frames per image; 0 is treated as 1
- iOFFSET_H_SIGN, iOFFSET_V_SIGN  in  1  offset signs
- iOFFSET_H, iOFFSET_V  in  8  offset magnitudes
- oFRAME_ID  out  FRAME_BITS  frame ID for the reader
- oOFFSET_H_SIGN, oOFFSET_V_SIGN  out  1  latched signs
- oOFFSET_H, oOFFSET_V  out  8  latched magnitudes
- oFRAME_TICK  out  1  one-cycle pulse on every output update
- oWRAP  out  1  one-cycle pulse when the sequence returns to its first frame
- oSTATE  out  2  state monitor: 0 = IDLE, 1 = MANUAL, 2 = RUN

## Operation
- **Synchronizer:** iVSYNC_N passes through a 2-flop synchronizer. A third register feeds a falling-edge detector. Each detected falling edge is one "boundary".
- **Reset:** all outputs, state (IDLE), dwell counter, current-frame register and latched range are 0.
- **State transitions:**
  - Any state with iENABLE=0 goes to IDLE on the next edge.
  - IDLE with iENABLE=1 goes to MANUAL if iRUN=0, or to RUN if iRUN=1.
  - MANUAL with iRUN=1 goes to RUN; RUN with iRUN=0 goes to MANUAL.
- **IDLE:** boundaries are ignored. Outputs hold their last values; oFRAME_TICK and oWRAP stay 0.
- **MANUAL:** at each boundary, oFRAME_ID ← iMANUAL_FRAME, all four offset outputs are relatched from inputs, and oFRAME_TICK pulses.
- **RUN entry** (the cycle of the transition into RUN):
  - Latch first, last and dwell; a latched dwell of 0 becomes 1.
  - Set cur ← first, cnt ← 0, primed ← 0.
  - Input changes to range or dwell while in RUN are ignored until RUN is re-entered.
- **RUN boundary:**
  - If primed=0: oFRAME_ID ← first, cnt ← 1, primed ← 1.
  - Else if cnt < dwell: cnt ← cnt+1; frame unchanged.
  - Else advance with cnt ← 1:
    - If cur == last or last < first: cur ← first and oWRAP pulses.
    - Otherwise cur ← cur+1.
  - oFRAME_ID ← cur (new value). Offsets are relatched and oFRAME_TICK pulses on every RUN boundary.
- **Degenerate range** (last < first): shows first forever, with oWRAP at every advance. first == last behaves the same way.
- **Simultaneous events:** a boundary in the same cycle as a state transition is dropped (no update, no tick).
- **Arithmetic:** cur+1 never exceeds last, so there is no FRAME_BITS wrap. cnt saturates at the maximum dwell.

## Timing
- Let E be the iCLK edge at which synchronizer stage 1 first captures iVSYNC_N=0.
- Outputs update at E+3. oFRAME_TICK and oWRAP are high for exactly the cycle following E+3.
- A low pulse on iVSYNC_N shorter than one iCLK period may be missed. The VGA sync pulse is many cycles long, so this does not occur in use.
- Offset inputs may change at any time; they are visible only after the next boundary.
- iRST_N low at any edge, including mid-run, restores all reset values on that edge.
- Minimum boundary spacing handled: 4 iCLK cycles.

## Test plan
- **Reset:** hold iRST_N=0 with random inputs.
  - All outputs are 0 and oSTATE=0.
  - Vsync pulses produce no ticks.
- **Manual mode:** iENABLE=1, iRUN=0, iMANUAL_FRAME=5, iOFFSET_H=8'h12 with sign 1; apply one vsync.
  - At E+3: oFRAME_ID=5, oOFFSET_H=8'h12, sign=1, one tick.
- **Sequencing:** iENABLE=1, iRUN=1, first=2, last=4, dwell=2; apply 8 vsyncs.
  - oFRAME_ID sequence 2,2,3,3,4,4,2,2.
  - oWRAP on the 7th boundary only; 8 ticks.
- **Dwell and degenerate range:** dwell=0 with first=1, last=3 gives 1,2,3,1 with wrap on the 4th boundary. first=7, last=3 gives 7 on every boundary with oWRAP on boundaries 2 onward.
- **Enable drop:** drop iENABLE after 3 frames of RUN (range 0..9).
  - oSTATE=0; outputs hold at 2; no ticks.
  - Re-enable: the first boundary gives oFRAME_ID=0. A boundary coincident with the transition cycle is dropped.
- **Mid-frame offset change and reset:** change iOFFSET_V mid-frame.
  - oOFFSET_V is unchanged until the next tick.
  - Asserting iRST_N=0 mid-run zeroes all outputs on that edge.
